// File: rtl/b2g_rr_arbiter_if.sv
// Handshake bundle between NREQ binary producers, the round-robin gray
// converter, and the single gray-code consumer.
interface b2g_rr_arbiter_if #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4,
    parameter int CNTW  = 16
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  out_valid;
    logic [WIDTH-1:0]      out_gray;
    logic [IDW-1:0]        out_id;
    logic                  out_ready;
    logic [CNTW-1:0]       conv_count;

    // Arbiter side
    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_gray, out_id, conv_count
    );

    // Producer/consumer side
    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_gray, out_id, conv_count
    );
endinterface

// File: rtl/b2g_rr_arbiter.sv
// Round-robin arbiter feeding one shared binary-to-gray converter with a
// single-entry registered output stage tagged by requester ID.
module b2g_rr_lane #(
    parameter int IDW  = 2,
    parameter int LANE = 0
) (
    input  logic [IDW-1:0] i_ptr,
    input  logic           i_valid,
    output logic           o_hi
);
    // Lane sits at or after the pointer: it wins before any wrapped lane.
    assign o_hi = i_valid && (32'(LANE) >= 32'(i_ptr));
endmodule

module b2g_rr_arbiter #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    b2g_rr_arbiter_if.slave  bus
);
    localparam int IDW = $clog2(NREQ);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [WIDTH-1:0]            r_gray;
    logic [IDW-1:0]              r_id;
    logic [IDW-1:0]              r_ptr;
    logic [CNTW-1:0]             r_cnt;

    logic [NREQ-1:0][WIDTH-1:0]  w_lane_data;
    logic [NREQ-1:0]             w_hi;
    logic [NREQ-1:0]             w_cand;
    logic [NREQ-1:0]             w_ready;
    logic [IDW-1:0]              w_gnt_id;
    logic                        w_gnt_vld;
    logic                        w_slot_free;
    logic [WIDTH-1:0]            w_bin;
    logic [WIDTH-1:0]            w_gray;

    assign w_slot_free = (r_state == EMPTY) || bus.out_ready;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
        assign w_lane_data[gi] = bus.req_data[gi*WIDTH +: WIDTH];

        b2g_rr_lane #(.IDW(IDW), .LANE(gi)) u_lane (
            .i_ptr   (r_ptr),
            .i_valid (bus.req_valid[gi]),
            .o_hi    (w_hi[gi])
        );
    end

    // Two-level priority: lowest lane at/after the pointer, else lowest overall.
    always_comb begin
        w_cand   = (|w_hi) ? w_hi : bus.req_valid;
        w_gnt_id = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (w_cand[i]) w_gnt_id = IDW'(i);
        end
        w_gnt_vld = (|w_cand) && w_slot_free && rst_n;
        w_ready   = '0;
        if (w_gnt_vld) w_ready[w_gnt_id] = 1'b1;
    end

    assign w_bin  = w_lane_data[w_gnt_id];
    assign w_gray = w_bin ^ (w_bin >> 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= EMPTY;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            EMPTY:   if (w_gnt_vld) w_state_nxt = FULL;
            FULL:    if (!w_gnt_vld && bus.out_ready) w_state_nxt = EMPTY;
            default: w_state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gray <= '0;
            r_id   <= '0;
            r_ptr  <= '0;
            r_cnt  <= '0;
        end else if (w_gnt_vld) begin
            r_gray <= w_gray;
            r_id   <= w_gnt_id;
            r_ptr  <= (w_gnt_id == IDW'(NREQ - 1)) ? '0 : w_gnt_id + 1'b1;
            r_cnt  <= r_cnt + 1'b1;
        end
    end

    assign bus.req_ready  = w_ready;
    assign bus.out_valid  = (r_state == FULL);
    assign bus.out_gray   = r_gray;
    assign bus.out_id     = r_id;
    assign bus.conv_count = r_cnt;
endmodule

// File: doc/b2g_rr_arbiter.md
Name: b2g_rr_arbiter

Overview:
Round-robin arbiter that shares one binary-to-gray conversion datapath among NREQ requesters. Each requester presents a binary word with a valid/ready handshake. The granted word is converted (gray = bin ^ (bin >> 1)) and registered into a single-entry output stage, tagged with the requester ID. The output stage uses a valid/ready handshake toward the consumer. The block sits between multiple pointer/counter producers and a shared gray-code sink (e.g. a CDC pointer bus).

Parameters:
WIDTH, 4, bit width of binary input and gray output
NREQ, 4, number of requesters (2..16)
IDW, $clog2(NREQ), width of requester ID (derived; not overridden)
CNTW, 16, width of conversion counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  NREQ  per-requester valid; bit i = requester i
req_data  input  NREQ*WIDTH  packed binary words; requester i at [i*WIDTH +: WIDTH]
req_ready  output  NREQ  per-requester accept; at most one bit high (one-hot or zero)
out_valid  output  1  output stage holds a converted word
out_gray  output  WIDTH  registered gray code of the accepted word
out_id  output  IDW  index of the requester whose word is in out_gray
out_ready  input  1  consumer accepts out_* this cycle
conv_count  output  CNTW  number of completed input transfers, wraps modulo 2^CNTW

Behaviour:
- Clocking: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: out_valid=0, out_gray=0, out_id=0, conv_count=0, rr_ptr=0. req_ready=0 while rst_n=0.
- Reset may assert at any cycle. It immediately drops out_valid and discards any held word. The first grant after reset release starts the search from requester 0.
- Slot free condition: slot_free = !out_valid | out_ready.
- Grant: combinational. When slot_free, grant the first i with req_valid[i]=1, searching i = rr_ptr, rr_ptr+1, ... modulo NREQ. Drive req_ready[i]=1 for that i only. When !slot_free or no valid, req_ready=0.
- Transfer: requester i transfers when req_valid[i] & req_ready[i]. On the next clk edge:
  - out_gray <= g(req_data word i)
  - out_id <= i
  - out_valid <= 1
  - rr_ptr <= (i+1) mod NREQ
  - conv_count <= conv_count+1 (wraps)
- Latency: exactly 1 cycle from input transfer to out_valid/out_gray.
- Throughput: 1 word/cycle when out_ready is held high.
- Drain without refill: out_valid & out_ready with no transfer -> out_valid <= 0. out_gray/out_id keep their last values.
- Simultaneous drain and accept: out_valid & out_ready & transfer -> the new word loads and out_valid stays 1 (no bubble).
- Stall: out_valid & !out_ready -> out_gray, out_id and out_valid hold stable, req_ready=0, rr_ptr and conv_count hold.
- No-grant cycles leave rr_ptr unchanged.
- Fairness: a continuously valid requester is granted within NREQ transfers.
- req_data of non-granted requesters is ignored. A requester may drop valid before it is granted, with no effect.
- Width rule: the conversion is bitwise over WIDTH bits. out_gray[WIDTH-1] = bin[WIDTH-1]; out_gray[k] = bin[k+1]^bin[k].
- State encoding: two-state view of the output stage, EMPTY (out_valid=0) and FULL (out_valid=1).
  - EMPTY -> FULL on transfer.
  - FULL -> EMPTY on out_ready with no transfer.
  - FULL -> FULL on stall, or on drain+accept.

Test Plan:
- Single requester 0, out_ready=1, data 0110,1001,1110,0001,1010 on consecutive cycles -> out_gray 0101,1101,1001,0001,1111 one cycle later each, out_id=0, conv_count=5.
- All four requesters valid continuously, out_ready=1, req i data=i+8 -> grants 0,1,2,3,0,1... one-hot req_ready; out_gray 1100,1101,1111,1110 repeating.
- FULL with out_ready=0 for 3 cycles, requesters 1,2 valid -> req_ready=0, out_gray/out_id stable; on out_ready=1 requester 1 granted that cycle, back-to-back data, no bubble.
- rr_ptr=2 after granting 1, only requesters 0 and 3 valid -> 3 granted first, then 0 (wrap-around).
- rst_n low mid-stream while FULL -> out_valid=0, out_gray=0, conv_count=0 immediately; after release, with requesters 1 and 2 valid, 1 granted first.
- conv_count at 0xFFFF, one more transfer -> 0x0000; WIDTH=8 build, input 0xFF -> out_gray 0x80.
